// File: rtl/shift_sequencer_pkg.sv
// Shared types and helpers for the shift_sequencer controller.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

  // Counter width able to hold the value WIDTH itself (no wrap at full length).
  function automatic int unsigned cnt_w_f(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shseq_piso.sv
// Parallel-load serialiser: presents the next bit of the loaded pattern on
// o_bit and flags o_last when that bit is the final one of the command.
module shseq_piso
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = cnt_w_f(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_dir,
  input  logic [CNT_W-1:0] i_len,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit,
  output logic             o_last
);

  logic [WIDTH-1:0] r_sh;
  logic             r_dir;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_pad;

  // For MSB-first the pattern is left-aligned so data[len-1] sits at the top.
  assign w_pad = CNT_W'(WIDTH) - i_len;

  // Load pattern/count, then shift one position and count down per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_dir <= DIR_MSB;
      r_rem <= '0;
    end else if (i_load) begin
      r_dir <= i_dir;
      r_rem <= i_len;
      r_sh  <= (i_dir == DIR_MSB) ? (i_data << w_pad) : i_data;
    end else if (i_step) begin
      r_sh  <= (r_dir == DIR_LSB) ? {1'b0, r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], 1'b0};
      r_rem <= r_rem - CNT_W'(1);
    end
  end

  assign o_bit  = (r_dir == DIR_LSB) ? r_sh[0] : r_sh[WIDTH-1];
  assign o_last = (r_rem == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for a bidirectional serial-in shift register.
// Optional stall input enabled by macro SHIFT_SEQUENCER_HOLD_EN.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = cnt_w_f(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SHIFT_SEQUENCER_HOLD_EN
  input  logic             hold,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             sr_d,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t r_state, w_state_nxt;
  logic   r_last, w_last_nxt;
  logic   w_en_nxt, w_dir_nxt, w_d_nxt, w_done_nxt, w_err_nxt;
  logic   w_load, w_step, w_bit, w_piso_last, w_len_bad, w_hold;

`ifdef SHIFT_SEQUENCER_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  assign cmd_ready = (r_state == IDLE);
  assign w_len_bad = (cmd_len == '0) || (cmd_len > CNT_W'(WIDTH));

  shseq_piso #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_piso (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_dir  (cmd_dir),
    .i_len  (cmd_len),
    .i_data (cmd_data),
    .o_bit  (w_bit),
    .o_last (w_piso_last)
  );

  // Next state and next registered outputs. r_last marks that the bit now on
  // sr_d is the final one, so the following edge ends the shift phase.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_en_nxt    = 1'b0;
    w_dir_nxt   = sr_dir;
    w_d_nxt     = sr_d;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          if (w_len_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_dir_nxt   = cmd_dir;
            w_state_nxt = SETUP;
          end
        end
      end
      SETUP: begin
        w_en_nxt    = 1'b1;
        w_d_nxt     = w_bit;
        w_step      = 1'b1;
        w_last_nxt  = w_piso_last;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (r_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else if (!w_hold) begin
          w_en_nxt   = 1'b1;
          w_d_nxt    = w_bit;
          w_step     = 1'b1;
          w_last_nxt = w_piso_last;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b0;
      sr_en   <= 1'b0;
      sr_dir  <= 1'b0;
      sr_d    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      sr_en   <= w_en_nxt;
      sr_dir  <= w_dir_nxt;
      sr_d    <= w_d_nxt;
      busy    <= (w_state_nxt != IDLE);
      done    <= w_done_nxt;
      err     <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: queue-based cycle model plus
// directed scenarios with literal expectations.
module tb_shift_sequencer;

  localparam int W  = 16;
  localparam int CW = 5;

  localparam int K_IDLE  = 0;
  localparam int K_SETUP = 1;
  localparam int K_SHIFT = 2;
  localparam int K_DONE  = 3;
  localparam int K_STALL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_len = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          cmd_ready, sr_en, sr_dir, sr_d, busy, done, err;
`ifdef SHIFT_SEQUENCER_HOLD_EN
  logic          hold = 1'b0;
`endif

  shift_sequencer #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SHIFT_SEQUENCER_HOLD_EN
    .hold      (hold),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .sr_en     (sr_en),
    .sr_dir    (sr_dir),
    .sr_d      (sr_d),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  typedef struct {
    int   kind;
    logic d;
    logic dir;
  } ent_t;

  ent_t q[$];
  logic m_en = 0, m_dir = 0, m_d = 0, m_busy = 0, m_done = 0, m_err = 0, m_idle = 1;
  int   m_kind = K_IDLE;

  initial begin
    ent_t e;
    bit   stall;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_en = 0; m_dir = 0; m_d = 0; m_busy = 0; m_done = 0; m_err = 0;
        m_idle = 1; m_kind = K_IDLE;
      end else begin
        m_err = 0;
        if (m_idle && cmd_valid) begin
          if (cmd_len == 0 || int'(cmd_len) > W) begin
            m_err = 1;
          end else begin
            e.kind = K_SETUP; e.d = 0; e.dir = cmd_dir;
            q.push_back(e);
            for (int k = 0; k < int'(cmd_len); k++) begin
              e.kind = K_SHIFT; e.dir = cmd_dir;
              e.d = cmd_dir ? cmd_data[k] : cmd_data[int'(cmd_len) - 1 - k];
              q.push_back(e);
            end
            e.kind = K_DONE; e.d = 0; e.dir = cmd_dir;
            q.push_back(e);
          end
        end
        stall = 0;
`ifdef SHIFT_SEQUENCER_HOLD_EN
        if (hold && (m_kind == K_SHIFT || m_kind == K_STALL) && q.size() > 0 && q[0].kind == K_SHIFT)
          stall = 1;
`endif
        if (stall) begin
          m_kind = K_STALL; m_en = 0; m_done = 0; m_busy = 1;
        end else if (q.size() > 0) begin
          e = q.pop_front();
          m_kind = e.kind;
          m_idle = 0;
          m_busy = 1;
          m_en   = (e.kind == K_SHIFT);
          m_done = (e.kind == K_DONE);
          if (e.kind == K_SHIFT) m_d = e.d;
          if (e.kind == K_SETUP) m_dir = e.dir;
        end else begin
          m_kind = K_IDLE; m_idle = 1; m_en = 0; m_busy = 0; m_done = 0;
        end
      end
    end
  end

  // ---------------- compare + capture on falling edge ----------------
  int          en_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, done_cyc = 0;
  logic [31:0] cap = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("sr_en", sr_en, m_en);
        chk("sr_dir", sr_dir, m_dir);
        chk("sr_d", sr_d, m_d);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("cmd_ready", cmd_ready, m_idle);
        if (sr_en) begin
          cap = {cap[30:0], sr_d};
          en_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (err) err_cnt++;
        if (busy) busy_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic d, input int len, input logic [15:0] data, output int acc);
    bit found;
    found = 0;
    acc = 0;
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_len   = CW'(len);
    cmd_data  = data;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        found = 1;
        acc = cyc;
      end
    end
    chk("accept_wait", {31'd0, found}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int a, a1, a2, e0, e1, d0, r0, b0;

    wait_cycles(3);
    chk("reset_outs", {26'd0, sr_en, sr_dir, sr_d, busy, done, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
    wait_cycles(1);

    // MSB-first, len 8 of 16'hA5C3 -> 1,1,0,0,0,0,1,1
    e0 = en_cnt; d0 = done_cnt;
    send(1'b0, 8, 16'hA5C3, a);
    wait_cycles(12);
    chk("A_bits", {24'd0, cap[7:0]}, 32'h0000_00C3);
    chk("A_en_cycles", en_cnt - e0, 32'd8);
    chk("A_done_pulses", done_cnt - d0, 32'd1);
    chk("A_done_latency", done_cyc - a, 32'd10);

    // LSB-first, len 4 of 16'h0006 -> 0,1,1,0
    e0 = en_cnt;
    send(1'b1, 4, 16'h0006, a);
    wait_cycles(10);
    chk("B_bits", {28'd0, cap[3:0]}, 32'h0000_0006);
    chk("B_en_cycles", en_cnt - e0, 32'd4);
    chk("B_done_latency", done_cyc - a, 32'd6);
    chk("B_dir_held_idle", {31'd0, sr_dir}, 32'd1);

    // Illegal lengths
    for (int t = 0; t < 2; t++) begin
      e0 = en_cnt; r0 = err_cnt; b0 = busy_cnt;
      send(1'b0, (t == 0) ? 0 : 17, 16'hFFFF, a);
      wait_cycles(4);
      chk("illegal_err_pulse", err_cnt - r0, 32'd1);
      chk("illegal_no_en", en_cnt - e0, 32'd0);
      chk("illegal_no_busy", busy_cnt - b0, 32'd0);
    end

    // Back-to-back: full-width command then a second held valid
    e0 = en_cnt;
    send(1'b0, 16, 16'hFFFF, a1);
    send(1'b0, 8, 16'h00F0, a2);
    chk("b2b_gap", a2 - a1, 32'd19);
    chk("b2b_first_en", en_cnt - e0, 32'd16);
    chk("b2b_first_bits", {16'd0, cap[15:0]}, 32'h0000_FFFF);

    // Reset during the 5th shift of the second command
    e1 = en_cnt; d0 = done_cnt;
    repeat (5) @(posedge clk);
    #3;
    chk("rst_mid_en_before", {31'd0, sr_en}, 32'd1);
    chk("rst_mid_en_count", en_cnt - e1, 32'd4);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", {29'd0, sr_en, busy, done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(20);
    chk("rst_mid_no_done", done_cnt - d0, 32'd0);
    chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);

`ifdef SHIFT_SEQUENCER_HOLD_EN
    // len 6 of 16'h002D -> 1,0,1,1,0,1 with a 3-cycle hold after bit 2
    e0 = en_cnt;
    send(1'b0, 6, 16'h002D, a);
    @(posedge clk);
    @(posedge clk);
    #1;
    hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    hold = 1'b0;
    wait_cycles(12);
    chk("hold_bits", {26'd0, cap[5:0]}, 32'h0000_002D);
    chk("hold_en_cycles", en_cnt - e0, 32'd6);
    chk("hold_done_latency", done_cyc - a, 32'd11);
`endif

    wait_cycles(3);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
